// File: rtl/rggen_bus_arbiter.sv
// rggen_bus_arbiter
// Shares one downstream register bus among NUM_MASTERS requesters. One transaction
// is in flight at a time. Masters are chosen round-robin in IDLE, the command is
// issued in ACCESS until the slave is ready or the timeout expires, and RESPOND
// returns a one-cycle done pulse to the owner.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   i_request         : per-master level request, held until o_done
//   i_address         : per-master byte address
//   i_write           : per-master direction (1 = write)
//   i_write_data      : per-master write data
//   i_strobe          : per-master byte enables
//   o_done            : one-cycle completion pulse to the owner
//   o_read_data       : read data, zero unless o_done is nonzero
//   o_status          : 00 OK, 01 slave error, 10 timeout; zero unless o_done is nonzero
//   o_grant           : one-hot current owner, zero when idle
//   o_bus_*           : downstream command
//   i_bus_ready       : downstream completion
//   i_bus_read_data   : downstream read data
//   i_bus_status      : downstream status, nonzero maps to 01
module rggen_bus_arbiter #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned ADDRESS_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_MASTERS-1:0]                        i_request,
    input  logic [NUM_MASTERS-1:0][ADDRESS_WIDTH-1:0]     i_address,
    input  logic [NUM_MASTERS-1:0]                        i_write,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]        i_write_data,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]      i_strobe,
    output logic [NUM_MASTERS-1:0]                        o_done,
    output logic [DATA_WIDTH-1:0]                         o_read_data,
    output logic [1:0]                                    o_status,
    output logic [NUM_MASTERS-1:0]                        o_grant,
    output logic                                          o_bus_request,
    output logic [ADDRESS_WIDTH-1:0]                      o_bus_address,
    output logic                                          o_bus_write,
    output logic [DATA_WIDTH-1:0]                         o_bus_write_data,
    output logic [DATA_WIDTH/8-1:0]                       o_bus_strobe,
    input  logic                                          i_bus_ready,
    input  logic [DATA_WIDTH-1:0]                         i_bus_read_data,
    input  logic [1:0]                                    i_bus_status
);

    localparam int unsigned IdxW  = $clog2(NUM_MASTERS);
    localparam int unsigned StrbW = DATA_WIDTH / 8;
    localparam int unsigned CntW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StRespond
    } state_e;

    state_e                   state_q, state_d;
    logic [IdxW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]          sel_q, sel_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic                     write_q, write_d;
    logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
    logic [StrbW-1:0]         strobe_q, strobe_d;
    logic [DATA_WIDTH-1:0]    read_data_q, read_data_d;
    logic [1:0]               status_q, status_d;
    logic [CntW-1:0]          count_q, count_d;

    logic                     req_found;
    logic [IdxW-1:0]          req_sel;
    int unsigned              cand_idx;

    // First requester at or above rr_ptr, wrapping modulo NUM_MASTERS.
    always_comb begin
        req_found = 1'b0;
        req_sel   = '0;
        cand_idx  = 0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            cand_idx = 32'(rr_ptr_q) + i;
            if (cand_idx >= NUM_MASTERS) begin
                cand_idx = cand_idx - NUM_MASTERS;
            end
            if (!req_found && i_request[IdxW'(cand_idx)]) begin
                req_found = 1'b1;
                req_sel   = IdxW'(cand_idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        sel_d        = sel_q;
        grant_d      = grant_q;
        address_d    = address_q;
        write_d      = write_q;
        write_data_d = write_data_q;
        strobe_d     = strobe_q;
        read_data_d  = read_data_q;
        status_d     = status_q;
        count_d      = count_q;
        unique case (state_q)
            StIdle: begin
                if (req_found) begin
                    state_d          = StAccess;
                    sel_d            = req_sel;
                    grant_d          = '0;
                    grant_d[req_sel] = 1'b1;
                    address_d        = i_address[req_sel];
                    write_d          = i_write[req_sel];
                    write_data_d     = i_write_data[req_sel];
                    strobe_d         = i_strobe[req_sel];
                    // count_q holds the number of the current ACCESS cycle
                    count_d          = CntW'(1);
                end
            end
            StAccess: begin
                if (i_bus_ready) begin
                    state_d     = StRespond;
                    read_data_d = write_q ? '0 : i_bus_read_data;
                    status_d    = (i_bus_status != 2'b00) ? 2'b01 : 2'b00;
                end else if (TIMEOUT_CYCLES != 0 && count_q == CntW'(TIMEOUT_CYCLES)) begin
                    state_d     = StRespond;
                    read_data_d = '0;
                    status_d    = 2'b10;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            StRespond: begin
                state_d  = StIdle;
                grant_d  = '0;
                count_d  = '0;
                rr_ptr_d = (sel_q == IdxW'(NUM_MASTERS - 1)) ? '0 : sel_q + 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            sel_q        <= '0;
            grant_q      <= '0;
            address_q    <= '0;
            write_q      <= 1'b0;
            write_data_q <= '0;
            strobe_q     <= '0;
            read_data_q  <= '0;
            status_q     <= 2'b00;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            sel_q        <= sel_d;
            grant_q      <= grant_d;
            address_q    <= address_d;
            write_q      <= write_d;
            write_data_q <= write_data_d;
            strobe_q     <= strobe_d;
            read_data_q  <= read_data_d;
            status_q     <= status_d;
            count_q      <= count_d;
        end
    end

    assign o_grant          = grant_q;
    assign o_bus_request    = (state_q == StAccess);
    assign o_bus_address    = address_q;
    assign o_bus_write      = write_q;
    assign o_bus_write_data = write_data_q;
    assign o_bus_strobe     = strobe_q;
    // Response fields are gated so they read zero outside the done pulse.
    assign o_done           = (state_q == StRespond) ? grant_q : '0;
    assign o_read_data      = (state_q == StRespond) ? read_data_q : '0;
    assign o_status         = (state_q == StRespond) ? status_q : 2'b00;

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// tb_rggen_bus_arbiter
// Self-checking bench for rggen_bus_arbiter with three masters and a timeout of 4.
// A transaction-level model (owner, elapsed access cycles, round-robin pointer)
// predicts every output each cycle; directed scenarios pin the model with literals,
// then a randomized phase exercises arbitration, timeouts, errors and resets.
module tb_rggen_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N-1:0]           request = '0;
    logic [N-1:0][AW-1:0]   address = '0;
    logic [N-1:0]           write = '0;
    logic [N-1:0][DW-1:0]   wdata = '0;
    logic [N-1:0][SW-1:0]   strobe = '0;
    logic [N-1:0]           o_done;
    logic [DW-1:0]          o_read_data;
    logic [1:0]             o_status;
    logic [N-1:0]           o_grant;
    logic                   o_bus_request;
    logic [AW-1:0]          o_bus_address;
    logic                   o_bus_write;
    logic [DW-1:0]          o_bus_write_data;
    logic [SW-1:0]          o_bus_strobe;
    logic                   bus_ready = 1'b0;
    logic [DW-1:0]          bus_read_data = '0;
    logic [1:0]             bus_status = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rggen_bus_arbiter #(
        .NUM_MASTERS    (N),
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_request        (request),
        .i_address        (address),
        .i_write          (write),
        .i_write_data     (wdata),
        .i_strobe         (strobe),
        .o_done           (o_done),
        .o_read_data      (o_read_data),
        .o_status         (o_status),
        .o_grant          (o_grant),
        .o_bus_request    (o_bus_request),
        .o_bus_address    (o_bus_address),
        .o_bus_write      (o_bus_write),
        .o_bus_write_data (o_bus_write_data),
        .o_bus_strobe     (o_bus_strobe),
        .i_bus_ready      (bus_ready),
        .i_bus_read_data  (bus_read_data),
        .i_bus_status     (bus_status)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Lowest offset k >= 0 such that master (ptr+k) mod N is requesting; -1 if none.
    function automatic int pick(input int ptr, input logic [N-1:0] req);
        pick = -1;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(ptr + k) % N]) pick = (ptr + k) % N;
        end
    endfunction

    // Transaction model: m_owner is the master in flight (-1 none), m_done is the
    // master whose completion is being reported this cycle (-1 none).
    bit             m_valid = 1'b0;
    int             m_owner = -1;
    int             m_done = -1;
    int             m_ptr = 0;
    int             m_age = 0;
    logic [AW-1:0]  m_addr;
    logic           m_write;
    logic [DW-1:0]  m_wdata;
    logic [SW-1:0]  m_strb;
    logic [DW-1:0]  m_rdata;
    logic [1:0]     m_status;

    always @(posedge clk) begin
        int p;
        if (rst) begin
            m_valid <= 1'b1;
            m_owner <= -1;
            m_done  <= -1;
            m_ptr   <= 0;
        end else if (m_done >= 0) begin
            m_ptr   <= (m_done + 1) % N;
            m_owner <= -1;
            m_done  <= -1;
        end else if (m_owner >= 0) begin
            if (bus_ready) begin
                m_done   <= m_owner;
                m_rdata  <= m_write ? '0 : bus_read_data;
                m_status <= (bus_status != 2'b00) ? 2'b01 : 2'b00;
            end else if (m_age + 1 == TO) begin
                m_done   <= m_owner;
                m_rdata  <= '0;
                m_status <= 2'b10;
            end
            m_age <= m_age + 1;
        end else begin
            p = pick(m_ptr, request);
            if (p >= 0) begin
                m_owner <= p;
                m_age   <= 0;
                m_addr  <= address[p];
                m_write <= write[p];
                m_wdata <= wdata[p];
                m_strb  <= strobe[p];
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        logic         ebr;
        if (m_valid) begin
            eg = '0;
            ed = '0;
            if (m_owner >= 0) eg[m_owner] = 1'b1;
            if (m_done >= 0) ed[m_done] = 1'b1;
            ebr = (m_owner >= 0) && (m_done < 0);
            check("model_grant", 64'(o_grant), 64'(eg));
            check("model_done", 64'(o_done), 64'(ed));
            check("model_bus_request", 64'(o_bus_request), 64'(ebr));
            check("model_read_data", 64'(o_read_data), (m_done >= 0) ? 64'(m_rdata) : 64'd0);
            check("model_status", 64'(o_status), (m_done >= 0) ? 64'(m_status) : 64'd0);
            if (ebr) begin
                check("model_bus_address", 64'(o_bus_address), 64'(m_addr));
                check("model_bus_write", 64'(o_bus_write), 64'(m_write));
                check("model_bus_write_data", 64'(o_bus_write_data), 64'(m_wdata));
                check("model_bus_strobe", 64'(o_bus_strobe), 64'(m_strb));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        request   = '0;
        bus_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int got[4];
        int exp_order[4];
        int ng;
        int cnt;
        bit seen;

        // Reset state.
        step();
        step();
        check("rst_grant", 64'(o_grant), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_bus_request", 64'(o_bus_request), 64'd0);
        check("rst_bus_write", 64'(o_bus_write), 64'd0);
        check("rst_status", 64'(o_status), 64'd0);
        check("rst_bus_address", 64'(o_bus_address), 64'd0);
        check("rst_bus_write_data", 64'(o_bus_write_data), 64'd0);
        check("rst_bus_strobe", 64'(o_bus_strobe), 64'd0);
        check("rst_read_data", 64'(o_read_data), 64'd0);
        rst = 1'b0;

        // Single read by master 0, slave ready on the first access cycle.
        do_reset();
        request[0] = 1'b1; address[0] = 8'h10; write[0] = 1'b0;
        bus_ready = 1'b1; bus_read_data = 32'hDEADBEEF; bus_status = 2'b00;
        step();
        check("rd_bus_request", 64'(o_bus_request), 64'd1);
        check("rd_bus_address", 64'(o_bus_address), 64'h10);
        check("rd_grant", 64'(o_grant), 64'b001);
        step();
        check("rd_done", 64'(o_done), 64'b001);
        check("rd_read_data", 64'(o_read_data), 64'hDEADBEEF);
        check("rd_status", 64'(o_status), 64'd0);
        request[0] = 1'b0;
        step();
        check("rd_done_clear", 64'(o_done), 64'd0);
        check("rd_grant_clear", 64'(o_grant), 64'd0);
        check("rd_read_data_zero", 64'(o_read_data), 64'd0);

        // Masters 0 and 1 request continuously: alternate grants.
        do_reset();
        exp_order = '{0, 1, 0, 1};
        got = '{-1, -1, -1, -1};
        ng = 0;
        request[0] = 1'b1; request[1] = 1'b1; write[0] = 1'b0; write[1] = 1'b0;
        bus_ready = 1'b1;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            step();
            if (o_done != '0) begin
                for (int m = 0; m < N; m++) if (o_done[m]) got[ng] = m;
                ng++;
            end
        end
        check("rr_done_count", 64'(ng), 64'd4);
        for (int i = 0; i < 4; i++) check("rr_order", 64'(got[i]), 64'(exp_order[i]));

        // Master 1 write, slave error.
        do_reset();
        request[1] = 1'b1; address[1] = 8'h24; write[1] = 1'b1;
        wdata[1] = 32'h00000101; strobe[1] = 4'hF;
        bus_ready = 1'b1; bus_status = 2'b01; bus_read_data = 32'hFFFFFFFF;
        step();
        check("wr_bus_write", 64'(o_bus_write), 64'd1);
        check("wr_bus_address", 64'(o_bus_address), 64'h24);
        check("wr_bus_write_data", 64'(o_bus_write_data), 64'h101);
        check("wr_bus_strobe", 64'(o_bus_strobe), 64'hF);
        check("wr_grant", 64'(o_grant), 64'b010);
        step();
        check("wr_done", 64'(o_done), 64'b010);
        check("wr_status", 64'(o_status), 64'b01);
        check("wr_read_data", 64'(o_read_data), 64'd0);
        request[1] = 1'b0;

        // Slave never ready: timeout after 4 access cycles.
        do_reset();
        request[0] = 1'b1; address[0] = 8'h30; write[0] = 1'b0;
        bus_ready = 1'b0; bus_read_data = 32'hA5A5A5A5; bus_status = 2'b00;
        cnt = 0;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            step();
            if (o_done != '0) seen = 1'b1;
            else if (o_bus_request) cnt++;
        end
        check("to_done_seen", 64'(seen), 64'd1);
        check("to_request_cycles", 64'(cnt), 64'd4);
        check("to_done", 64'(o_done), 64'b001);
        check("to_status", 64'(o_status), 64'b10);
        check("to_read_data", 64'(o_read_data), 64'd0);
        request[0] = 1'b0;

        // Ready on the 4th access cycle wins over the timeout.
        do_reset();
        request[2] = 1'b1; address[2] = 8'h40; write[2] = 1'b0;
        bus_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("rw_bus_request", 64'(o_bus_request), 64'd1);
            if (i == 4) begin
                bus_ready = 1'b1; bus_read_data = 32'h12345678; bus_status = 2'b00;
            end
        end
        step();
        check("rw_done", 64'(o_done), 64'b100);
        check("rw_status", 64'(o_status), 64'd0);
        check("rw_read_data", 64'(o_read_data), 64'h12345678);
        request[2] = 1'b0;

        // Reset mid-access aborts and restarts round robin at master 0.
        do_reset();
        request[0] = 1'b1; write[0] = 1'b0; bus_ready = 1'b1; bus_status = 2'b00;
        step();
        step();
        request[0] = 1'b0;
        step();
        request[0] = 1'b1; request[1] = 1'b1; bus_ready = 1'b0;
        step();
        check("ra_grant_before", 64'(o_grant), 64'b010);
        check("ra_bus_request_before", 64'(o_bus_request), 64'd1);
        rst = 1'b1;
        step();
        check("ra_bus_request_after", 64'(o_bus_request), 64'd0);
        check("ra_done_after", 64'(o_done), 64'd0);
        check("ra_grant_after", 64'(o_grant), 64'd0);
        rst = 1'b0; bus_ready = 1'b1;
        step();
        check("ra_first_grant", 64'(o_grant), 64'b001);

        // Randomized traffic checked by the model.
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            for (int m = 0; m < N; m++) begin
                if (o_done[m]) begin
                    request[m] = 1'b0;
                end else if (!request[m] && ($urandom % 4 == 0)) begin
                    request[m] = 1'b1;
                    address[m] = AW'($urandom);
                    write[m]   = 1'($urandom);
                    wdata[m]   = $urandom;
                    strobe[m]  = SW'($urandom);
                end else if (o_grant[m] && ($urandom % 3 == 0)) begin
                    // Owner's command changes must not reach the bus.
                    address[m] = AW'($urandom);
                    write[m]   = 1'($urandom);
                    wdata[m]   = $urandom;
                    strobe[m]  = SW'($urandom);
                end
            end
            bus_ready     = ($urandom % 3 == 0);
            bus_read_data = $urandom;
            bus_status    = ($urandom % 4 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rst           = ($urandom % 300 == 0);
        end
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
